// File: rtl/jtcontra_palmix_pkg.sv
// Shared constants, types and helpers for the Contra / Combat School palette mixer.
// Palette entry layout: low byte = {G[2:0],R[4:0]}, high byte = {unused,B[4:0],G[4:3]}.
package jtcontra_palmix_pkg;

  localparam int         PIPE_DEPTH    = 3;
  localparam logic [3:0] TRANSP_COLOUR = 4'd0;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb_t;

  // A layer pixel shows only when its layer is enabled and its colour code is not the transparent one
  function automatic logic pxl_opaque(input logic [6:0] pxl, input logic en);
    return en && (pxl[3:0] != TRANSP_COLOUR);
  endfunction

  // e = {high[6:0], low[7:0]}; the spare top bit of the high byte never reaches here
  function automatic rgb_t pal_decode(input logic [14:0] e);
    rgb_t c;
    c.r = e[4:0];
    c.g = {e[9:8], e[7:5]};
    c.b = e[14:10];
    return c;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port 0 read/write, port 1 read-only. Reads are asynchronous, so a
// read on the same clk as a write to the same word returns the old contents.
module jtframe_dual_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] data0_i,
  output logic [DW-1:0] q0_o,
  input  logic [AW-1:0] addr1_i,
  output logic [DW-1:0] q1_o
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];

  // Storage is never cleared so the palette survives a reset
  always_ff @(posedge clk) begin
    if (we0_i) begin
      mem_q[addr0_i] <= data0_i;
    end
  end

  assign q0_o = mem_q[addr0_i];
  assign q1_o = mem_q[addr1_i];

endmodule

// File: rtl/jtcontra_palmix.sv
// Palette mixer: picks the winning layer pixel, looks it up in the CPU-written
// palette and drives 5-bit RGB with blanking, all on a 3-stage pxl_cen pipeline.
import jtcontra_palmix_pkg::*;

module jtcontra_palmix #(
  parameter int GAME = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  output logic       LHBL_dly,
  output logic       LVBL_dly,
  input  logic       pal_cs,
  input  logic       cpu_rnw,
  input  logic       cpu_cen,
  input  logic [8:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic       prio,
  input  logic [6:0] gfx1_pxl,
  input  logic [6:0] gfx2_pxl,
  input  logic [1:0] gfx_en,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue
);

  logic                  cpu_we_s;
  logic [7:0]            even_cpu_s, odd_cpu_s, even_vid_s, odd_vid_s;
  logic                  hi_unused_s;
  logic                  op1_s, op2_s, prio_s, win2_s;
  logic [7:0]            idx_q, idx_d;
  logic [14:0]           pal_q, pal_d;
  rgb_t                  rgb_q, rgb_d;
  logic [PIPE_DEPTH-1:0] lhbl_q, lhbl_d, lvbl_q, lvbl_d;
  logic [7:0]            dout_q, dout_d;

  assign cpu_we_s    = pal_cs & ~cpu_rnw & cpu_cen;
  assign hi_unused_s = odd_vid_s[7];

  // Even bank holds low bytes, odd bank high bytes, so video fetches a whole entry at once
  jtframe_dual_ram #(.AW(8), .DW(8)) u_even (
    .clk     (clk),
    .we0_i   (cpu_we_s & ~cpu_addr[0]),
    .addr0_i (cpu_addr[8:1]),
    .data0_i (cpu_dout),
    .q0_o    (even_cpu_s),
    .addr1_i (idx_q),
    .q1_o    (even_vid_s)
  );

  jtframe_dual_ram #(.AW(8), .DW(8)) u_odd (
    .clk     (clk),
    .we0_i   (cpu_we_s & cpu_addr[0]),
    .addr0_i (cpu_addr[8:1]),
    .data0_i (cpu_dout),
    .q0_o    (odd_cpu_s),
    .addr1_i (idx_q),
    .q1_o    (odd_vid_s)
  );

  // Layer arbitration: with both layers transparent gfx2 supplies the backdrop
  always_comb begin
    op1_s  = pxl_opaque(gfx1_pxl, gfx_en[0]);
    op2_s  = pxl_opaque(gfx2_pxl, gfx_en[1]);
    prio_s = (GAME != 0) ? prio : 1'b0;
    if (prio_s) begin
      win2_s = op2_s | ~op1_s;
    end else begin
      win2_s = ~op1_s;
    end
  end

  // Next state for the video pipeline and the CPU readback register
  always_comb begin
    idx_d  = idx_q;
    pal_d  = pal_q;
    rgb_d  = rgb_q;
    lhbl_d = lhbl_q;
    lvbl_d = lvbl_q;
    dout_d = dout_q;
    if (pxl_cen) begin
      idx_d  = {win2_s, win2_s ? gfx2_pxl : gfx1_pxl};
      pal_d  = {odd_vid_s[6:0], even_vid_s};
      lhbl_d = {lhbl_q[PIPE_DEPTH-2:0], LHBL};
      lvbl_d = {lvbl_q[PIPE_DEPTH-2:0], LVBL};
      if (lhbl_q[PIPE_DEPTH-2] && lvbl_q[PIPE_DEPTH-2]) begin
        rgb_d = pal_decode(pal_q);
      end else begin
        rgb_d = '0;
      end
    end else begin
      idx_d = idx_q;
    end
    if (pal_cs) begin
      dout_d = cpu_addr[0] ? odd_cpu_s : even_cpu_s;
    end else begin
      dout_d = dout_q;
    end
  end

  // State registers; reset wins over pxl_cen
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 8'd0;
      pal_q  <= 15'd0;
      rgb_q  <= '0;
      lhbl_q <= '0;
      lvbl_q <= '0;
      dout_q <= 8'd0;
    end else begin
      idx_q  <= idx_d;
      pal_q  <= pal_d;
      rgb_q  <= rgb_d;
      lhbl_q <= lhbl_d;
      lvbl_q <= lvbl_d;
      dout_q <= dout_d;
    end
  end

  assign red      = rgb_q.r;
  assign green    = rgb_q.g;
  assign blue     = rgb_q.b;
  assign LHBL_dly = lhbl_q[PIPE_DEPTH-1];
  assign LVBL_dly = lvbl_q[PIPE_DEPTH-1];
  assign pal_dout = dout_q;

endmodule

// File: tb/tb_jtcontra_palmix.sv
// Randomised bench for jtcontra_palmix against a pixel-level reference model,
// plus directed colour, priority, collision and reset cases.
module tb_jtcontra_palmix;

  logic       clk = 1'b0;
  logic       rst, pxl_cen, LHBL, LVBL, pal_cs, cpu_rnw, cpu_cen, prio;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic [6:0] gfx1_pxl, gfx2_pxl;
  logic [1:0] gfx_en;
  logic       LHBL_dly, LVBL_dly, LHBL_dly0, LVBL_dly0;
  logic [7:0] pal_dout, pal_dout0;
  logic [4:0] red, green, blue, red0, green0, blue0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit dout_en = 0;

  always #5 clk = ~clk;

  jtcontra_palmix #(.GAME(1)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
    .cpu_cen(cpu_cen), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
    .prio(prio), .gfx1_pxl(gfx1_pxl), .gfx2_pxl(gfx2_pxl), .gfx_en(gfx_en),
    .red(red), .green(green), .blue(blue)
  );

  jtcontra_palmix #(.GAME(0)) dut0 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .LHBL_dly(LHBL_dly0), .LVBL_dly(LVBL_dly0), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
    .cpu_cen(cpu_cen), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout0),
    .prio(prio), .gfx1_pxl(gfx1_pxl), .gfx2_pxl(gfx2_pxl), .gfx_en(gfx_en),
    .red(red0), .green(green0), .blue(blue0)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  pal_m [0:511];
  int          n = 0;
  bit          h_lh [0:7], h_lv [0:7];
  logic [7:0]  h_ix1 [0:7], h_ix0 [0:7];
  logic [14:0] h_c1 [0:7], h_c0 [0:7];
  logic [14:0] exp_rgb1 = 15'd0, exp_rgb0 = 15'd0;
  bit          exp_lh = 0, exp_lv = 0;
  logic [7:0]  exp_dout = 8'd0;

  function automatic logic [7:0] ref_index(input bit combat, input bit p,
      input logic [6:0] g1, input logic [6:0] g2, input logic [1:0] en);
    bit vis1, vis2;
    vis1 = en[0] && ((g1 & 7'h0F) != 7'd0);
    vis2 = en[1] && ((g2 & 7'h0F) != 7'd0);
    if (combat && p && vis2) return 8'h80 | {1'b0, g2};
    if (vis1) return {1'b0, g1};
    return 8'h80 | {1'b0, g2};
  endfunction

  function automatic logic [14:0] ref_colour(input logic [7:0] lo, input logic [7:0] hi);
    int r, g, b;
    r = lo % 32;
    g = lo / 32 + (hi % 4) * 8;
    b = (hi / 4) % 32;
    return {r[4:0], g[4:0], b[4:0]};
  endfunction

  // Output after pxl_cen n shows the pixel sampled at n-2 in the colour the palette held at n-1
  always @(posedge clk) begin
    int k, km1, km2;
    if (rst) begin
      n++;
      k = n & 7; km1 = (n - 1) & 7;
      h_lh[k] = 0; h_lv[k] = 0; h_lh[km1] = 0; h_lv[km1] = 0;
      h_ix1[k] = 8'd0; h_ix0[k] = 8'd0; h_c1[k] = 15'd0; h_c0[k] = 15'd0;
      exp_rgb1 = 15'd0; exp_rgb0 = 15'd0; exp_lh = 0; exp_lv = 0; exp_dout = 8'd0;
    end else begin
      if (pxl_cen) begin
        n++;
        k = n & 7; km1 = (n - 1) & 7; km2 = (n - 2) & 7;
        h_lh[k]  = LHBL;
        h_lv[k]  = LVBL;
        h_ix1[k] = ref_index(1, prio, gfx1_pxl, gfx2_pxl, gfx_en);
        h_ix0[k] = ref_index(0, prio, gfx1_pxl, gfx2_pxl, gfx_en);
        h_c1[k]  = ref_colour(pal_m[2*h_ix1[km1]], pal_m[2*h_ix1[km1]+1]);
        h_c0[k]  = ref_colour(pal_m[2*h_ix0[km1]], pal_m[2*h_ix0[km1]+1]);
        exp_lh   = h_lh[km2];
        exp_lv   = h_lv[km2];
        exp_rgb1 = (h_lh[km2] && h_lv[km2]) ? h_c1[km1] : 15'd0;
        exp_rgb0 = (h_lh[km2] && h_lv[km2]) ? h_c0[km1] : 15'd0;
      end
      if (pal_cs) begin
        exp_dout = pal_m[cpu_addr];
        if (!cpu_rnw && cpu_cen) pal_m[cpu_addr] = cpu_dout;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("rgb_game1", {1'b0, red, green, blue}, {1'b0, exp_rgb1});
      check_eq("rgb_game0", {1'b0, red0, green0, blue0}, {1'b0, exp_rgb0});
      check_eq("lhbl_dly", {15'd0, LHBL_dly}, {15'd0, exp_lh});
      check_eq("lvbl_dly", {15'd0, LVBL_dly}, {15'd0, exp_lv});
      if (dout_en) check_eq("pal_dout", {8'd0, pal_dout}, {8'd0, exp_dout});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pxl_cen = (cyc % 4 == 0);
  endtask

  // Returns just before the next pxl_cen edge
  task automatic to_cen();
    do step(); while (!pxl_cen);
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = a; cpu_dout = d;
    step();
    pal_cs = 1'b0; cpu_rnw = 1'b1;
  endtask

  task automatic cpu_rd(input logic [8:0] a);
    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_cen = 1'b1; cpu_addr = a;
    step();
    pal_cs = 1'b0;
  endtask

  function automatic logic [6:0] rand_pxl();
    logic [6:0] v;
    v = 7'($urandom);
    if ($urandom_range(0, 3) == 0) v = v & 7'h70;
    return v;
  endfunction

  task automatic show_pixel(input logic [6:0] g1, input logic [6:0] g2, input bit p,
                            input logic [1:0] en, input logic [14:0] exp1, input logic [14:0] exp0,
                            input string tag);
    to_cen();
    gfx1_pxl = g1; gfx2_pxl = g2; prio = p; gfx_en = en;
    to_cen(); to_cen(); to_cen();
    step();
    @(negedge clk);
    check_eq({tag, "_g1"}, {1'b0, red, green, blue}, {1'b0, exp1});
    check_eq({tag, "_g0"}, {1'b0, red0, green0, blue0}, {1'b0, exp0});
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
    cpu_cen = 1'b0; cpu_addr = 9'd0; cpu_dout = 8'd0; prio = 1'b0;
    gfx1_pxl = 7'd0; gfx2_pxl = 7'd0; gfx_en = 2'b11;
    step();
    chk_en = 1;
    step(); step();
    rst = 1'b0;

    for (int a = 0; a < 512; a++) cpu_wr(9'(a), 8'($urandom));
    for (int i = 0; i < 4; i++) to_cen();
    cpu_rd(9'd0);
    dout_en = 1;

    LHBL = 1'b1; LVBL = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) LHBL = ~LHBL;
      if ($urandom_range(0, 149) == 0) LVBL = ~LVBL;
      gfx1_pxl = rand_pxl();
      gfx2_pxl = rand_pxl();
      gfx_en   = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
      prio     = 1'($urandom);
      pal_cs   = ($urandom_range(0, 3) == 0);
      cpu_rnw  = 1'($urandom);
      cpu_cen  = ($urandom_range(0, 3) != 0);
      cpu_addr = 9'($urandom);
      cpu_dout = 8'($urandom);
      step();
    end
    pal_cs = 1'b0; cpu_rnw = 1'b1; LHBL = 1'b1; LVBL = 1'b1; gfx_en = 2'b11; prio = 1'b0;

    cpu_wr(9'h000, 8'h1F); cpu_wr(9'h001, 8'h00);
    cpu_wr(9'h002, 8'h1F); cpu_wr(9'h003, 8'h00);
    cpu_wr(9'h024, 8'h1F); cpu_wr(9'h025, 8'h00);
    cpu_wr(9'h146, 8'h00); cpu_wr(9'h147, 8'h7C);
    cpu_wr(9'h160, 8'hE0); cpu_wr(9'h161, 8'h03);
    cpu_wr(9'h00A, 8'h1F); cpu_wr(9'h00B, 8'h00);

    show_pixel(7'h01, 7'h00, 0, 2'b11, {5'd31, 5'd0, 5'd0},  {5'd31, 5'd0, 5'd0},  "entry1_red");
    show_pixel(7'h12, 7'h23, 0, 2'b11, {5'd31, 5'd0, 5'd0},  {5'd31, 5'd0, 5'd0},  "prio0");
    show_pixel(7'h12, 7'h23, 1, 2'b11, {5'd0,  5'd0, 5'd31}, {5'd31, 5'd0, 5'd0},  "prio1");
    show_pixel(7'h10, 7'h30, 0, 2'b11, {5'd0,  5'd31, 5'd0}, {5'd0,  5'd31, 5'd0}, "backdrop");
    show_pixel(7'h12, 7'h30, 1, 2'b00, {5'd0,  5'd31, 5'd0}, {5'd0,  5'd31, 5'd0}, "layers_off");

    // Blank for 10 pixels; the model checks the delayed blanks and black RGB
    to_cen();
    LHBL = 1'b0;
    for (int i = 0; i < 10; i++) to_cen();
    LHBL = 1'b1;
    for (int i = 0; i < 4; i++) to_cen();

    // Rewrite entry 5 while the pipeline is fetching it
    to_cen();
    gfx1_pxl = 7'h05; gfx2_pxl = 7'h00; prio = 1'b0; gfx_en = 2'b11;
    to_cen();
    cpu_wr(9'h00A, 8'h00);
    cpu_wr(9'h00B, 8'h7C);
    to_cen(); step();
    @(negedge clk);
    check_eq("collide_old", {1'b0, red, green, blue}, {1'b0, 5'd31, 5'd0, 5'd0});
    to_cen(); step();
    @(negedge clk);
    check_eq("collide_new", {1'b0, red, green, blue}, {1'b0, 5'd0, 5'd0, 5'd31});
    cpu_rd(9'h00A);
    @(negedge clk);
    check_eq("readback_lo", {8'd0, pal_dout}, 16'h0000);
    cpu_rd(9'h00B);
    @(negedge clk);
    check_eq("readback_hi", {8'd0, pal_dout}, 16'h007C);

    // One-clk reset with pxl_cen low
    step();
    if (pxl_cen) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rgb", {1'b0, red, green, blue}, 16'h0000);
    check_eq("rst_blank", {14'd0, LHBL_dly, LVBL_dly}, 16'h0000);
    check_eq("rst_dout", {8'd0, pal_dout}, 16'h0000);
    cpu_rd(9'h00B);
    @(negedge clk);
    check_eq("rst_keep_pal", {8'd0, pal_dout}, 16'h007C);
    for (int i = 0; i < 4; i++) to_cen();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
